// File: rtl/hilo_md_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit feeding the HI/LO pair.
// Optional build macro HILO_FAST_MULT_EN: single-cycle mult/multu, divides stay iterative.
module hilo_md_ctrl #(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;      // mult: upper accumulator word; div: partial remainder
  logic [WIDTH-1:0] q_reg;      // mult: multiplier / low product; div: dividend / quotient
  logic [WIDTH-1:0] b_reg;      // mult: multiplicand; div: divisor
  logic [WIDTH-1:0] opa_raw_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             div0_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_com_reg;
  logic [WIDTH-1:0] lo_com_reg;

  logic             issue;
  logic             is_fast;
  logic             signed_op;
  logic             last_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign issue     = (state_reg == ST_IDLE) & start & ~flush;
  assign signed_op = ~md_op[0];
  assign abs_a     = (signed_op && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
  assign abs_b     = (signed_op && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
  assign last_step = (cnt_reg == CW'(WIDTH - 1));

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
  assign is_fast   = ~md_op[1];
`else
  assign is_fast   = 1'b0;
`endif

  // Control: stall is combinational so the issuing instruction holds in its own cycle.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    hilo_we    = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (issue) begin
          stall      = 1'b1;
          state_next = is_fast ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (flush)          state_next = ST_IDLE;
        else if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        if (!flush) hilo_we = 2'b11;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_q;

  // One iteration: shift-add (LSB first) or restoring divide (MSB first).
  always_comb begin
    mul_sum   = {1'b0, a_reg} + (q_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
    div_shift = {a_reg, q_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    step_a    = a_reg;
    step_q    = q_reg;
    if (op_reg[1]) begin
      if (div_diff[WIDTH]) begin
        step_a = div_shift[WIDTH-1:0];
        step_q = {q_reg[WIDTH-2:0], 1'b0};
      end else begin
        step_a = div_diff[WIDTH-1:0];
        step_q = {q_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_a = mul_sum[WIDTH:1];
      step_q = {mul_sum[0], q_reg[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Sign fix-up of magnitude results; product negated as a whole 2W-bit word.
  always_comb begin
    prod_raw = {a_reg, q_reg};
    prod_fix = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = neg_q_reg ? (~q_reg + 1'b1) : q_reg;
    rem_fix  = neg_r_reg ? (~a_reg + 1'b1) : a_reg;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (op_reg[1]) begin
      if (div0_reg) begin
        res_hi = opa_raw_reg;
        res_lo = DIV0_LO;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= 2'b00;
      a_reg       <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      opa_raw_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      cnt_reg     <= '0;
      hi_com_reg  <= '0;
      lo_com_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue) begin
            op_reg      <= md_op;
            opa_raw_reg <= opa;
            neg_q_reg   <= signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_r_reg   <= signed_op & opa[WIDTH-1];
            div0_reg    <= md_op[1] & (opb == '0);
            cnt_reg     <= '0;
            a_reg       <= '0;
            if (md_op[1]) begin
              q_reg <= abs_a;
              b_reg <= abs_b;
            end else begin
              q_reg <= abs_b;
              b_reg <= abs_a;
            end
`ifdef HILO_FAST_MULT_EN
            if (!md_op[1]) begin
              a_reg <= fast_prod[2*WIDTH-1:WIDTH];
              q_reg <= fast_prod[WIDTH-1:0];
            end
`endif
          end
        end
        ST_RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          a_reg   <= step_a;
          q_reg   <= step_q;
        end
        ST_DONE: begin
          if (!flush) begin
            hi_com_reg <= res_hi;
            lo_com_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Outside DONE the write data holds the last committed result.
  assign hi_wdata = (state_reg == ST_DONE) ? res_hi : hi_com_reg;
  assign lo_wdata = (state_reg == ST_DONE) ? res_lo : lo_com_reg;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: expected HI/LO and commit cycle queued at issue.
module tb_hilo_md_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   md_op = 2'b00;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic [1:0]   hilo_we;
  logic [W-1:0] hi_wdata;
  logic [W-1:0] lo_wdata;

  hilo_md_ctrl #(.WIDTH(W), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .opa(opa), .opb(opb),
    .flush(flush), .stall(stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb2;
    int     qa, qb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      2'b00: p = 64'(sa * sb2);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else p = {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic int latency(input logic [1:0] op);
`ifdef HILO_FAST_MULT_EN
    return op[1] ? W + 1 : 1;
`else
    return (op != 2'b11) ? W + 1 : W + 1;
`endif
  endfunction

  // Commit monitor: every hilo_we pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && hilo_we != 2'b00) begin
      if (sb.size() == 0) begin
        check_val("unexpected_commit", {62'b0, hilo_we}, 64'h0);
      end else begin
        cur = sb.pop_front();
        check_val({cur.tag, "_we"}, {62'b0, hilo_we}, 64'h3);
        check_val({cur.tag, "_hi"}, {32'b0, hi_wdata}, {32'b0, cur.hi});
        check_val({cur.tag, "_lo"}, {32'b0, lo_wdata}, {32'b0, cur.lo});
        check_val({cur.tag, "_cycle"}, 64'(cyc), 64'(cur.cyc));
        check_val({cur.tag, "_stall_done"}, {63'b0, stall}, 64'h0);
        $display("commit %s: hi=%08h lo=%08h cycle=%0d", cur.tag, hi_wdata, lo_wdata, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one issue strobe for a single cycle; returns in cycle T+1.
  task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push, output int t);
    exp_t e;
    logic [63:0] r;
    start = 1'b1;
    md_op = op;
    opa   = a;
    opb   = b;
    t     = cyc;
    if (push) begin
      r     = model(op, a, b);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.cyc = t + latency(op);
      e.tag = tag;
      sb.push_back(e);
    end
    #1;
    check_val({tag, "_stall_issue"}, {63'b0, stall}, 64'h1);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, "_drained"}, 64'(sb.size()), 64'h0);
    tick();
  endtask

  int t;
  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_stall", {63'b0, stall}, 64'h0);
    check_val("rst_we", {62'b0, hilo_we}, 64'h0);
    check_val("rst_hi", {32'b0, hi_wdata}, 64'h0);
    check_val("rst_lo", {32'b0, lo_wdata}, 64'h0);

    issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'h2, 1'b1, t);
`ifndef HILO_FAST_MULT_EN
    while (cyc < t + W) tick();
    check_val("multu_stall_last_run", {63'b0, stall}, 64'h1);
`endif
    drain("multu_max");

    issue("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b1, t);
    drain("mult_neg");
    issue("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b1, t);
    drain("div_neg");
    issue("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b1, t);
    drain("divu_100_7");
    issue("divu_zero", 2'b11, 32'h1234, 32'h0, 1'b1, t);
    drain("divu_zero");
    issue("div_zero", 2'b10, 32'h87654321, 32'h0, 1'b1, t);
    drain("div_zero");
    issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, t);
    drain("div_ovf");
    issue("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 1'b1, t);
    drain("mult_minmin");

    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (i % 4 == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      issue($sformatf("rand%0d", i), r_op, r_a, r_b, 1'b1, t);
      drain($sformatf("rand%0d", i));
    end

    // Flush mid-divide: no commit, back to IDLE, then a fresh issue.
    issue("div_flushed", 2'b10, 32'd1000, 32'd3, 1'b0, t);
    while (cyc < t + 10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_stall", {63'b0, stall}, 64'h0);
    check_val("flush_we", {62'b0, hilo_we}, 64'h0);
    tick();
    issue("after_flush", 2'b10, 32'hFFFFFF00, 32'd9, 1'b1, t);
    drain("after_flush");

    // A start pulse during RUN must be ignored.
    issue("divu_busy", 2'b11, 32'd1000, 32'd10, 1'b1, t);
    tick();
    tick();
    start = 1'b1;
    md_op = 2'b11;
    opa   = 32'd5;
    opb   = 32'd1;
    tick();
    start = 1'b0;
    drain("divu_busy");
    repeat (40) tick();
    check_val("no_extra_commit", 64'(sb.size()), 64'h0);

    // Reset mid-divide clears everything on the next cycle.
    issue("div_reset", 2'b10, 32'd500, 32'hFFFFFFFD, 1'b0, t);
    while (cyc < t + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_stall", {63'b0, stall}, 64'h0);
    check_val("mid_rst_we", {62'b0, hilo_we}, 64'h0);
    check_val("mid_rst_hi", {32'b0, hi_wdata}, 64'h0);
    check_val("mid_rst_lo", {32'b0, lo_wdata}, 64'h0);
    repeat (40) tick();

    issue("post_rst_mult", 2'b00, 32'd12345, 32'hFFFFFFFE, 1'b1, t);
    drain("post_rst_mult");
    check_val("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
